// File: rtl/step_pkg.sv
// Shared FSM state and mode encodings for the single-step debug controller.
package step_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStepCyc,
    StStepIns,
    StRun,
    StBreak
  } state_e;

  typedef enum logic [1:0] {
    ModeHalt    = 2'b00,
    ModeStepCyc = 2'b01,
    ModeStepIns = 2'b10,
    ModeRun     = 2'b11
  } mode_e;

  // States in which the CPU is clocked.
  function automatic logic is_exec(state_e s);
    return (s == StStepCyc) || (s == StStepIns) || (s == StRun);
  endfunction

endpackage

// File: rtl/db_chan.sv
// One button channel: 2-flop synchroniser, counting debouncer, rising-edge pulse.
module db_chan #(
  parameter int unsigned DB_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam logic [DB_BITS-1:0] CntOne = DB_BITS'(1);

  logic               sync1_q, sync2_q;
  logic               level_q, level_prev_q, pulse_q;
  logic [DB_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
      // Any disagreement must persist for a full counter wrap before it is accepted.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (&cnt_q) begin
        cnt_q   <= '0;
        level_q <= ~level_q;
      end else begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/step_ctrl.sv
// Debug step controller: debounced buttons drive halt / step-cycle / step-instruction /
// run-to-breakpoint control of a registered CPU clock enable, plus an executed-cycle counter.
module step_ctrl
  import step_pkg::*;
#(
  parameter int unsigned NBTN    = 4,
  parameter int unsigned DB_BITS = 16,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBTN-1:0]  btn,
  input  logic [1:0]       mode,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             instr_done,
  output logic [NBTN-1:0]  btn_level,
  output logic [NBTN-1:0]  btn_pulse,
  output logic             cpu_ce,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    db_chan #(
      .DB_BITS(DB_BITS)
    ) u_db_chan (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

  state_e           state_q, state_d;
  logic             mask_q, mask_d;
  logic             cpu_ce_q, halted_q;
  logic [CNT_W-1:0] cyc_q;
  mode_e            mode_s;
  logic             start, stop, bp_hit, halt_st;

  assign mode_s  = mode_e'(mode);
  // Stop wins over a simultaneous start.
  assign stop    = btn_pulse[1];
  assign start   = btn_pulse[0] & ~btn_pulse[1];
  assign bp_hit  = instr_done & bp_en & (pc == bp_addr);
  assign halt_st = (state_q == StIdle) || (state_q == StBreak);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (mode_s)
            ModeStepCyc: state_d = StStepCyc;
            ModeStepIns: state_d = StStepIns;
            ModeRun: begin
              state_d = StRun;
              mask_d  = 1'b0;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StStepCyc: state_d = StIdle;
      StStepIns: if (instr_done) state_d = StIdle;
      StRun: begin
        if (stop || (mode_s == ModeHalt)) begin
          state_d = StIdle;
          mask_d  = 1'b0;
        end else if (instr_done) begin
          // The first completed instruction after a resume never re-triggers the break.
          mask_d = 1'b0;
          if (bp_hit && !mask_q) state_d = StBreak;
        end
      end
      StBreak: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
          mask_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mask_q   <= 1'b0;
      cpu_ce_q <= 1'b0;
      halted_q <= 1'b1;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cpu_ce_q <= is_exec(state_d);
      halted_q <= ~is_exec(state_d);
      if (halt_st && btn_pulse[NBTN-1]) begin
        cyc_q <= '0;
      end else if (cpu_ce_q && !(&cyc_q)) begin
        cyc_q <= cyc_q + CntOne;
      end
    end
  end

  assign cpu_ce  = cpu_ce_q;
  assign halted  = halted_q;
  assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: expected cpu_ce bursts are queued, a monitor checks each one.
module tb_step_ctrl;

  localparam int NBTN = 4;
  localparam int DB   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = '0;
  logic [1:0]  mode = 2'b00;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc = '0;
  logic        instr_done = 1'b0;
  logic [3:0]  btn_level, btn_pulse;
  logic        cpu_ce, halted;
  logic [31:0] cyc_cnt;

  step_ctrl #(
    .NBTN   (NBTN),
    .DB_BITS(DB),
    .PC_W   (32),
    .CNT_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .mode      (mode),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .instr_done(instr_done),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .cpu_ce    (cpu_ce),
    .halted    (halted),
    .cyc_cnt   (cyc_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected burst: ce-high length and cyc_cnt right after it ends.
  typedef struct {
    int id;
    int len;
    int cnt;
  } burst_t;

  burst_t exp_q[$];
  burst_t e;
  int     run_len = 0;

  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
    end else if (cpu_ce) begin
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_burst: got length %0d, expected none", run_len);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("burst%0d_len", e.id), 32'(run_len), 32'(e.len));
        check($sformatf("burst%0d_cnt", e.id), cyc_cnt, 32'(e.cnt));
        check($sformatf("burst%0d_halted", e.id), 32'(halted), 32'd1);
      end
      run_len = 0;
    end
  end

  // CPU model: 4 enabled cycles per instruction, pc advances by 4 per instruction.
  int          uc = 0;
  logic        ce_s = 1'b0, done_s = 1'b0;
  int          load_req = 0, load_ack = 0;
  logic [31:0] load_pc = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      uc     = 0;
      ce_s   = 1'b0;
      done_s = 1'b0;
    end else if (ce_s) begin
      if (done_s) begin
        uc = 0;
        pc = pc + 32'd4;
      end else begin
        uc++;
      end
    end
    if (load_req != load_ack) begin
      pc       = load_pc;
      uc       = 0;
      load_ack = load_req;
    end
    ce_s       = cpu_ce;
    instr_done = cpu_ce && (uc == 3);
    done_s     = instr_done;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int i);
    btn[i] = 1'b1;
    cyc(25);
    btn[i] = 1'b0;
    cyc(25);
  endtask

  task automatic cpu_load(input logic [31:0] addr);
    load_pc = addr;
    load_req++;
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat;
  int seen;

  initial begin
    #2 rst = 1'b0;
    cyc(3);
    @(negedge clk);
    check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_pulse", 32'(btn_pulse), 32'd0);
    check("rst_cyc_cnt", cyc_cnt, 32'd0);
    rst = 1'b1;
    cyc(2);

    // Bounce with mode halt: level timing checked, pulse must not start anything.
    for (int i = 0; i < 4; i++) begin
      btn[0] = ~btn[0];
      cyc(2);
    end
    btn[0] = 1'b1;
    lat = 0;
    while (!btn_level[0] && lat < 40) begin
      cyc(1);
      lat++;
    end
    check("db_latency", 32'(lat), 32'd18);
    cyc(1);
    check("db_pulse_high", 32'(btn_pulse[0]), 32'd1);
    cyc(1);
    check("db_pulse_low", 32'(btn_pulse[0]), 32'd0);
    check("halt_mode_no_ce", 32'(cpu_ce), 32'd0);
    btn[0] = 1'b0;
    seen = 0;
    repeat (25) begin
      cyc(1);
      if (btn_pulse[0]) seen++;
    end
    check("no_fall_pulse", 32'(seen), 32'd0);
    check("db_level_low", 32'(btn_level[0]), 32'd0);

    // Step one cycle.
    mode = 2'b01;
    exp_q.push_back('{id: 1, len: 1, cnt: 1});
    press(0);
    check("step_cyc_cnt", cyc_cnt, 32'd1);

    // Step one instruction from a fresh instruction boundary.
    cpu_load(32'h0);
    mode = 2'b10;
    exp_q.push_back('{id: 2, len: 4, cnt: 5});
    press(0);
    check("step_ins_halted", 32'(halted), 32'd1);

    // Clear the cycle counter while idle.
    press(3);
    check("cnt_clear", cyc_cnt, 32'd0);

    // Run until breakpoint at 0x10 completes (5 instructions).
    cpu_load(32'h0);
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    mode    = 2'b11;
    exp_q.push_back('{id: 3, len: 20, cnt: 20});
    press(0);
    check("break_halted", 32'(halted), 32'd1);
    check("break_ce", 32'(cpu_ce), 32'd0);

    // Resume at 0x10: masked match, keeps running until stop 30 cycles later.
    cpu_load(32'h10);
    exp_q.push_back('{id: 4, len: 30, cnt: 50});
    btn[0] = 1'b1;
    cyc(30);
    btn[1] = 1'b1;
    cyc(25);
    btn = '0;
    cyc(25);

    // Mode switched to halt while running.
    bp_en = 1'b0;
    exp_q.push_back('{id: 5, len: 21, cnt: 71});
    btn[0] = 1'b1;
    cyc(40);
    mode = 2'b00;
    cyc(10);
    btn[0] = 1'b0;
    cyc(25);
    mode = 2'b11;

    // Start and stop pulses in the same cycle while running.
    exp_q.push_back('{id: 6, len: 50, cnt: 121});
    btn[0] = 1'b1;
    cyc(25);
    btn[0] = 1'b0;
    cyc(25);
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    cyc(25);
    btn = '0;
    cyc(25);
    check("both_halted", 32'(halted), 32'd1);

    // Reset in the middle of a run.
    btn[0] = 1'b1;
    cyc(30);
    check("run_active", 32'(cpu_ce), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd1);
    check("mid_rst_cyc_cnt", cyc_cnt, 32'd0);
    check("mid_rst_level", 32'(btn_level), 32'd0);
    check("mid_rst_pulse", 32'(btn_pulse), 32'd0);
    btn[0] = 1'b0;
    cyc(3);
    rst  = 1'b1;
    seen = 0;
    repeat (30) begin
      cyc(1);
      if (cpu_ce) seen++;
    end
    check("post_rst_no_ce", 32'(seen), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
